flow_key_extract: RTL and testbench

Passive tap on the 256-bit AXI4-Stream ingress datapath. For every IPv4 packet it extracts the 5-tuple, folds it into a table address, and drives the per-packet `addr_hash`/`proc_port` strobe plus the `cnt_time` interval counter consumed by the per-second flow-feature counters. It is the producer side of that key interface. It never back-pressures the datapath.

---
 rtl/flow_key_extract_pkg.sv | 55 +++++
 rtl/xor_fold_hash.sv | 22 ++
 rtl/flow_key_extract.sv | 143 ++++++++++++++
 tb/tb_flow_key_extract.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/flow_key_extract_pkg.sv
// Shared header offsets, key layout and helpers for the flow-key tap and the flow-feature blocks.
// Pure definitions: no latency, no flow control.
package flow_key_extract_pkg;

  localparam int ETH_DST_OFF   = 0;
  localparam int ETH_TYPE_OFF  = 12;
  localparam int IP_IHL_OFF    = 14;
  localparam int IP_PROTO_OFF  = 23;
  localparam int IP_SRC_OFF    = 26;
  localparam int IP_DST_OFF    = 30;
  localparam int L4_PORTS_OFF  = 34;
  localparam int BEAT_BYTES    = 32;
  localparam int MAC_KEY_BYTES = 14;
  localparam int TUSER_SRC_LSB = 16;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_TCP   = 8'd6;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [3:0]  IHL_NO_OPTS    = 4'd5;
  localparam logic [2:0]  PROC_PORT_IDLE = 3'd6;
  localparam logic [2:0]  PROC_PORT_DMA  = 3'd4;

  localparam int KEY_W     = 104;
  localparam int MAC_KEY_W = 8 * MAC_KEY_BYTES;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [7:0]  proto;
  } flow_key_t;

  typedef enum logic [1:0] {ST_SYNC, ST_HDR1, ST_HDR2, ST_BODY} parse_state_t;

  // n bytes starting at byte offset off, network order, right-aligned.
  function automatic logic [MAC_KEY_W-1:0] be_bytes(input logic [255:0] dat, input int off, input int n);
    logic [MAC_KEY_W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[(n-1-i)*8 +: 8] = dat[(off+i)*8 +: 8];
    return r;
  endfunction

  // {valid, proc_port}: even one-hot bits are MAC ports, odd bits are DMA.
  function automatic logic [3:0] encode_port(input logic [7:0] src);
    logic [3:0] r;
    r = '0;
    if (src != 8'd0 && (src & (src - 8'd1)) == 8'd0) begin
      for (int i = 0; i < 8; i++)
        if (src[i]) r = {1'b1, i[0] ? PROC_PORT_DMA : 3'(i / 2)};
    end
    return r;
  endfunction

endpackage

// File: rtl/xor_fold_hash.sv
// Folds an IN_WIDTH key into DEPTH_WIDTH bits by XOR of zero-padded chunks.
// Purely combinational, zero latency; no flow control.
module xor_fold_hash #(
  parameter int IN_WIDTH    = 104,
  parameter int DEPTH_WIDTH = 10
) (
  input  logic [IN_WIDTH-1:0]    key,
  output logic [DEPTH_WIDTH-1:0] hash
);

  localparam int CHUNKS = (IN_WIDTH + DEPTH_WIDTH - 1) / DEPTH_WIDTH;

  logic [CHUNKS*DEPTH_WIDTH-1:0] padded;

  always_comb begin
    padded = '0;
    padded[IN_WIDTH-1:0] = key;
    hash = '0;
    for (int i = 0; i < CHUNKS; i++) hash = hash ^ padded[i*DEPTH_WIDTH +: DEPTH_WIDTH];
  end

endmodule

// File: rtl/flow_key_extract.sv
// Passive 5-tuple tap: emits addr_hash/proc_port strobe per IPv4 packet plus cnt_time; FLOW_KEY_NONIP_EN adds MAC keys.
// Key registered one cycle after the HDR2 beat (or HDR1 beat for single-beat MAC keys).
// Never back-pressures; beats count only on tvalid & tready.
module flow_key_extract
  import flow_key_extract_pkg::*;
#(
  parameter int          DEPTH_WIDTH          = 10,
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned INTERVAL_CYCLES      = 160000000
) (
  input  logic                            asclk,
  input  logic                            aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]  tap_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] tap_tuser,
  input  logic                            tap_tvalid,
  input  logic                            tap_tready,
  input  logic                            tap_tlast,
  output logic [27:0]                     cnt_time,
  output logic [2:0]                      proc_port,
  output logic [DEPTH_WIDTH-1:0]          addr_hash,
  output logic                            key_valid
);

  localparam logic [27:0] CNT_MAX = 28'(INTERVAL_CYCLES);

  parse_state_t         state;
  logic                 tap_beat;
  logic [MAC_KEY_W-1:0] mac_q;
  logic [3:0]           ihl_q;
  logic [7:0]           proto_q;
  logic [31:0]          sip_q;
  logic [15:0]          dip_hi_q;
  logic [7:0]           port_q;

  logic [MAC_KEY_W-1:0] cur_mac;
  logic [3:0]           cur_ihl;
  logic [7:0]           cur_proto;
  logic [31:0]          cur_sip;
  logic [15:0]          cur_dip_hi, dip_lo, sport, dport;
  logic                 ports_ok;
  flow_key_t            ip_key;
  logic [DEPTH_WIDTH-1:0] ip_hash, emit_hash;
  logic [3:0]           port_enc;
  logic                 emit;
  logic                 unused_ok;

  assign tap_beat  = tap_tvalid & tap_tready;
  assign unused_ok = ^{tap_tdata, tap_tuser, mac_q};

  // Beat-1 fields are read live in HDR1; beat-2 offsets are rebased by one beat.
  always_comb begin
    cur_mac    = be_bytes(tap_tdata, ETH_DST_OFF, MAC_KEY_BYTES);
    cur_ihl    = 4'(be_bytes(tap_tdata, IP_IHL_OFF, 1));
    cur_proto  = 8'(be_bytes(tap_tdata, IP_PROTO_OFF, 1));
    cur_sip    = 32'(be_bytes(tap_tdata, IP_SRC_OFF, 4));
    cur_dip_hi = 16'(be_bytes(tap_tdata, IP_DST_OFF, 2));
    dip_lo     = 16'(be_bytes(tap_tdata, IP_DST_OFF + 2 - BEAT_BYTES, 2));
    sport      = 16'(be_bytes(tap_tdata, L4_PORTS_OFF - BEAT_BYTES, 2));
    dport      = 16'(be_bytes(tap_tdata, L4_PORTS_OFF + 2 - BEAT_BYTES, 2));
  end

  always_comb begin
    ports_ok      = (proto_q == IP_PROTO_TCP || proto_q == IP_PROTO_UDP) && ihl_q == IHL_NO_OPTS;
    ip_key.src_ip = sip_q;
    ip_key.dst_ip = {dip_hi_q, dip_lo};
    ip_key.sport  = ports_ok ? sport : 16'd0;
    ip_key.dport  = ports_ok ? dport : 16'd0;
    ip_key.proto  = proto_q;
  end

  xor_fold_hash #(.IN_WIDTH(KEY_W), .DEPTH_WIDTH(DEPTH_WIDTH)) u_ip_hash (
    .key  (ip_key),
    .hash (ip_hash)
  );

`ifdef FLOW_KEY_NONIP_EN
  logic [MAC_KEY_W-1:0]   mac_key;
  logic [DEPTH_WIDTH-1:0] mac_hash;

  assign mac_key = (state == ST_HDR1) ? cur_mac : mac_q;

  xor_fold_hash #(.IN_WIDTH(MAC_KEY_W), .DEPTH_WIDTH(DEPTH_WIDTH)) u_mac_hash (
    .key  (mac_key),
    .hash (mac_hash)
  );
`endif

  always_comb begin
    port_enc  = encode_port(state == ST_HDR1 ? tap_tuser[TUSER_SRC_LSB +: 8] : port_q);
    emit      = 1'b0;
    emit_hash = ip_hash;
    if (tap_beat && port_enc[3]) begin
      if (state == ST_HDR2 && mac_q[15:0] == ETHERTYPE_IPV4) begin
        emit = 1'b1;
      end
`ifdef FLOW_KEY_NONIP_EN
      else if (state == ST_HDR2 || (state == ST_HDR1 && tap_tlast)) begin
        emit      = 1'b1;
        emit_hash = mac_hash;
      end
`endif
    end
  end

  always_ff @(posedge asclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_SYNC;
      cnt_time  <= '0;
      proc_port <= PROC_PORT_IDLE;
      addr_hash <= '0;
      key_valid <= 1'b0;
      mac_q     <= '0;
      ihl_q     <= '0;
      proto_q   <= '0;
      sip_q     <= '0;
      dip_hi_q  <= '0;
      port_q    <= '0;
    end else begin
      cnt_time  <= (cnt_time == CNT_MAX) ? 28'd0 : cnt_time + 28'd1;
      key_valid <= emit;
      proc_port <= emit ? port_enc[2:0] : PROC_PORT_IDLE;
      if (emit) addr_hash <= emit_hash;
      if (tap_beat) begin
        case (state)
          ST_SYNC: if (tap_tlast) state <= ST_HDR1;
          ST_HDR1: begin
            mac_q    <= cur_mac;
            ihl_q    <= cur_ihl;
            proto_q  <= cur_proto;
            sip_q    <= cur_sip;
            dip_hi_q <= cur_dip_hi;
            port_q   <= tap_tuser[TUSER_SRC_LSB +: 8];
            if (!tap_tlast) state <= ST_HDR2;
          end
          ST_HDR2: state <= tap_tlast ? ST_HDR1 : ST_BODY;
          default: if (tap_tlast) state <= ST_HDR1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flow_key_extract.sv
// Randomised scoreboard bench for flow_key_extract against a byte-level reference model.
`timescale 1ns/1ps
module tb_flow_key_extract;

  localparam int DW  = 10;
  localparam int IVL = 10;

  logic          asclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [255:0]  tap_tdata = '0;
  logic [127:0]  tap_tuser = '0;
  logic          tap_tvalid = 1'b0;
  logic          tap_tready = 1'b0;
  logic          tap_tlast = 1'b0;
  logic [27:0]   cnt_time;
  logic [2:0]    proc_port;
  logic [DW-1:0] addr_hash;
  logic          key_valid;

  always #5 asclk = ~asclk;

  flow_key_extract #(
    .DEPTH_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(256), .C_S_AXIS_TUSER_WIDTH(128), .INTERVAL_CYCLES(IVL)
  ) dut (
    .asclk(asclk), .aresetn(aresetn), .tap_tdata(tap_tdata), .tap_tuser(tap_tuser),
    .tap_tvalid(tap_tvalid), .tap_tready(tap_tready), .tap_tlast(tap_tlast),
    .cnt_time(cnt_time), .proc_port(proc_port), .addr_hash(addr_hash), .key_valid(key_valid)
  );

  typedef struct {
    int unsigned   cyc;
    logic [2:0]    port;
    logic [DW-1:0] hash;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned neg_cnt = 0;
  int          exp_cnt = 0;
  logic [DW-1:0] last_hash = '0;
  bit          synced = 1'b0;
  bit          throttle = 1'b0;
  logic [7:0]  pkt [0:95];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Bit b of the zero-extended key lands in hash bit b mod DW.
  function automatic logic [DW-1:0] fold(input logic [111:0] k);
    logic [DW-1:0] h;
    h = '0;
    for (int b = 0; b < 112; b++) h[b % DW] = h[b % DW] ^ k[b];
    return h;
  endfunction

  function automatic void model(input int len, input logic [7:0] ub,
                                output bit has, output logic [2:0] port, output logic [DW-1:0] hash);
    logic [111:0] k;
    logic [31:0]  l4;
    has = 1'b0; port = 3'd6; hash = '0; k = '0;
    if ($countones(ub) != 1) return;
    for (int b = 0; b < 8; b++) if (ub[b]) port = (b % 2 == 1) ? 3'd4 : 3'(b / 2);
    if (len > 32 && {pkt[12], pkt[13]} == 16'h0800) begin
      l4 = ((pkt[23] == 8'd6 || pkt[23] == 8'd17) && pkt[14][3:0] == 4'd5)
           ? {pkt[34], pkt[35], pkt[36], pkt[37]} : 32'h0;
      k = {8'h00, pkt[26], pkt[27], pkt[28], pkt[29], pkt[30], pkt[31], pkt[32], pkt[33], l4, pkt[23]};
      has = 1'b1; hash = fold(k);
    end else begin
`ifdef FLOW_KEY_NONIP_EN
      for (int i = 0; i < 14; i++) k[(13-i)*8 +: 8] = pkt[i];
      has = 1'b1; hash = fold(k);
`endif
    end
  endfunction

  always @(negedge asclk) begin
    exp_t e;
    neg_cnt++;
    if (!aresetn) begin
      check("rst_cnt_time", cnt_time, 0);
      check("rst_proc_port", proc_port, 6);
      check("rst_addr_hash", addr_hash, 0);
      check("rst_key_valid", key_valid, 0);
      exp_cnt = 0; last_hash = '0; sb.delete();
    end else begin
      check("cnt_time", cnt_time, exp_cnt);
      exp_cnt = (exp_cnt == IVL) ? 0 : exp_cnt + 1;
      check("key_valid_vs_port", key_valid, proc_port != 3'd6);
      if (key_valid) begin
        if (sb.size() == 0) check("unexpected_key", key_valid, 0);
        else begin
          e = sb.pop_front();
          check("key_cycle", neg_cnt, e.cyc);
          check("proc_port", proc_port, e.port);
          check("addr_hash", addr_hash, e.hash);
          last_hash = e.hash;
        end
      end else check("idle_hold", {proc_port, addr_hash}, {3'd6, last_hash});
    end
  end

  task automatic send_beat(input int j, input logic [7:0] ub, input bit last);
    bit acc;
    int tries;
    acc = 1'b0; tries = 0;
    while (!acc) begin
      @(negedge asclk);
      for (int i = 0; i < 32; i++) tap_tdata[i*8 +: 8] = pkt[j*32 + i];
      tap_tuser = {$urandom, $urandom, $urandom, $urandom};
      tap_tuser[23:16] = ub;
      tap_tvalid = 1'b1;
      tap_tlast = last;
      tap_tready = (throttle && tries < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
      tries++;
      @(posedge asclk);
      acc = tap_tready;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge asclk);
      tap_tvalid = 1'b0;
      tap_tlast = 1'b0;
      tap_tready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic build(input int len, input logic [15:0] et, input logic [7:0] vihl,
                       input logic [7:0] proto, input bit zero);
    for (int i = 0; i < 96; i++) pkt[i] = zero ? 8'h00 : 8'($urandom);
    pkt[12] = et[15:8]; pkt[13] = et[7:0]; pkt[14] = vihl; pkt[23] = proto;
  endtask

  task automatic send_packet(input int len, input logic [7:0] ub, input bit direct,
                             input logic [2:0] dport, input logic [DW-1:0] dhash);
    bit has;
    logic [2:0] p;
    logic [DW-1:0] h;
    int nb;
    nb = len / 32;
    model(len, ub, has, p, h);
    if (direct) begin has = 1'b1; p = dport; h = dhash; end
    for (int j = 0; j < nb; j++) begin
      send_beat(j, ub, j == nb - 1);
      if (synced && has && j == ((nb == 1) ? 0 : 1)) sb.push_back('{neg_cnt + 1, p, h});
    end
    synced = 1'b1;
  endtask

  initial begin
    int len;
    logic [7:0] ub;
    logic [15:0] et;
    logic [7:0] proto;
    logic [7:0] ubs [0:9];
    ubs = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h05};

    repeat (2) @(posedge asclk);
    #2 aresetn = 1'b1;
    idle(14);

    // First packet after reset only synchronises; the identical second one yields proto-only key.
    build(64, 16'h0800, 8'h45, 8'd17, 1'b1);
    send_packet(64, 8'h10, 1'b0, 3'd0, '0);
    send_packet(64, 8'h10, 1'b1, 3'd2, 10'h011);
    idle(2);

    build(64, 16'h0800, 8'h46, 8'd6, 1'b0);
    pkt[34] = 8'h12; pkt[35] = 8'h34; pkt[36] = 8'hab; pkt[37] = 8'hcd;
    send_packet(64, 8'h01, 1'b0, 3'd0, '0);
    build(64, 16'h0800, 8'h45, 8'd6, 1'b0);
    send_packet(64, 8'h02, 1'b0, 3'd0, '0);
    send_packet(64, 8'h05, 1'b0, 3'd0, '0);
    send_packet(64, 8'h00, 1'b0, 3'd0, '0);
    build(64, 16'h0806, 8'h00, 8'd0, 1'b0);
    send_packet(64, 8'h04, 1'b0, 3'd0, '0);
    send_packet(32, 8'h40, 1'b0, 3'd0, '0);
    build(32, 16'h0800, 8'h45, 8'd17, 1'b0);
    send_packet(32, 8'h01, 1'b0, 3'd0, '0);
    idle(3);

    throttle = 1'b1;
    for (int n = 0; n < 40; n++) begin
      len   = 32 * $urandom_range(1, 3);
      et    = ($urandom_range(0, 3) == 0) ? 16'h0806 : 16'h0800;
      proto = ($urandom_range(0, 2) == 0) ? 8'd1 : (($urandom_range(0, 1) == 1) ? 8'd6 : 8'd17);
      ub    = ubs[$urandom_range(0, 9)];
      build(len, et, ($urandom_range(0, 1) == 1) ? 8'h45 : 8'h46, proto, 1'b0);
      send_packet(len, ub, 1'b0, 3'd0, '0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    throttle = 1'b0;
    idle(3);

    // Reset between the two beats of a packet: its key must never appear.
    build(64, 16'h0800, 8'h45, 8'd17, 1'b0);
    send_beat(0, 8'h01, 1'b0);
    #2 aresetn = 1'b0;
    synced = 1'b0;
    idle(2);
    @(posedge asclk);
    #2 aresetn = 1'b1;
    send_packet(64, 8'h01, 1'b0, 3'd0, '0);
    build(64, 16'h0800, 8'h45, 8'd6, 1'b0);
    send_packet(64, 8'h08, 1'b0, 3'd0, '0);
    idle(5);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
